// File: rtl/demux_1_8_seq_pkg.sv
// Shared types and constants for the demux_1_8_seq block.
package demux_pkg;

  localparam int SEL_W   = 3;
  localparam int NUM_OUT = 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } demux_state_t;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/demux_1_8_seq_if.sv
// Data/handshake bundle for demux_1_8_seq. The frame_parity signal exists only
// when DEMUX_PARITY_EN is defined.
interface demux_1_8_seq_if #(
  parameter int WIDTH = 1
);
  import demux_pkg::*;

  logic [WIDTH-1:0]         D;
  logic                     S0;
  logic                     S1;
  logic                     S2;
  logic                     auto_mode;
  logic                     start;
  logic                     in_valid;
  logic                     in_ready;
  logic                     frame_ack;
  logic [NUM_OUT*WIDTH-1:0] out;
  logic [NUM_OUT-1:0]       lane_valid;
  logic                     frame_done;
`ifdef DEMUX_PARITY_EN
  logic                     frame_parity;
`endif

  // Producer/consumer side: drives data, selects and control.
  modport master (
    output D, S0, S1, S2, auto_mode, start, in_valid, frame_ack,
    input  in_ready, out, lane_valid, frame_done
`ifdef DEMUX_PARITY_EN
    , input frame_parity
`endif
  );

  // Demux side.
  modport slave (
    input  D, S0, S1, S2, auto_mode, start, in_valid, frame_ack,
    output in_ready, out, lane_valid, frame_done
`ifdef DEMUX_PARITY_EN
    , output frame_parity
`endif
  );

endinterface

// File: rtl/demux_1_8_seq_sel_counter.sv
// 3-bit auto-increment lane counter: synchronous clear has priority over enable,
// wraps 7 -> 0.
module demux_sel_counter
  import demux_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic en,
  output sel_t cnt
);

  // Counter register: clear on reset/start, advance on auto-mode accepts.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + sel_t'(1);
    end
  end

endmodule

// File: rtl/demux_1_8_seq.sv
// Registered 1-to-8 demultiplexer with frame sequencing.
// Optional macro DEMUX_PARITY_EN adds a registered frame_parity output holding
// the XOR of the whole completed lane bank.
module demux_1_8_seq
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  demux_1_8_seq_if.slave    bus
);

  demux_state_t             state;
  sel_t                     cnt;
  sel_t                     sel;
  logic                     accept;
  logic                     in_ready_q;
  logic                     frame_done_q;
  logic [NUM_OUT*WIDTH-1:0] bank_q;
  logic [NUM_OUT*WIDTH-1:0] bank_next;
  logic [NUM_OUT-1:0]       lv_q;
  logic [NUM_OUT-1:0]       lv_next;
`ifdef DEMUX_PARITY_EN
  logic                     parity_q;
`endif

  // start outranks a same-cycle in_valid, so a restart never also writes a lane.
  assign accept = bus.in_valid && in_ready_q && !bus.start;
  assign sel    = bus.auto_mode ? cnt : {bus.S2, bus.S1, bus.S0};

  demux_sel_counter u_cnt (
    .clk (clk),
    .clr (rst || bus.start),
    .en  (accept && bus.auto_mode),
    .cnt (cnt)
  );

  // Bank and valid flags as they would look after writing D into lane sel.
  always_comb begin
    bank_next = bank_q;
    lv_next   = lv_q;
    bank_next[sel*WIDTH +: WIDTH] = bus.D;
    lv_next[sel] = 1'b1;
  end

  // Frame FSM with registered in_ready/frame_done and the lane register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bank_q       <= '0;
      lv_q         <= '0;
      in_ready_q   <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef DEMUX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      if (bus.start) begin
        // Start from any state opens a fresh, empty frame.
        state      <= FILL;
        bank_q     <= '0;
        lv_q       <= '0;
        in_ready_q <= 1'b1;
`ifdef DEMUX_PARITY_EN
        parity_q   <= 1'b0;
`endif
      end else begin
        case (state)
          FILL: begin
            if (accept) begin
              bank_q <= bank_next;
              lv_q   <= lv_next;
              if (&lv_next) begin
                state        <= DONE;
                in_ready_q   <= 1'b0;
                frame_done_q <= 1'b1;
`ifdef DEMUX_PARITY_EN
                parity_q     <= ^bank_next;
`endif
              end
            end
          end
          DONE: begin
            if (bus.frame_ack) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.out        = bank_q;
  assign bus.lane_valid = lv_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.frame_done = frame_done_q;
`ifdef DEMUX_PARITY_EN
  assign bus.frame_parity = parity_q;
`endif

endmodule
